disparity_wta: RTL and testbench

Winner-take-all disparity selector directly downstream of the window SAD stage. Consumes a stream of SAD costs, one per disparity candidate, in order d = 0 … MAX_DISP-1 for each pixel. Tracks the running minimum and emits, once per pixel, the winning disparity and its cost to the disparity-map writer through a valid/ready handshake.

---
 rtl/stereo_pkg.sv | 25 ++
 rtl/wta_min_update.sv | 58 +++++
 rtl/disparity_wta.sv | 110 +++++++++++
 tb/tb_disparity_wta.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stereo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stereo_pkg
// Description : Shared stereo-pipeline parameters and types (SAD stage and
//               disparity winner-take-all).
// Revision    : 1.0 - initial release
// ============================================================================
package stereo_pkg;

  // Cost width: a 3x3 window of 8-bit pixels sums to at most 2295
  localparam int SAD_W    = 12;
  localparam int MAX_DISP = 64;

  // Disparity index width; at least one bit even for a single candidate
  function automatic int disp_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DISP_W = disp_width(MAX_DISP);

  typedef logic [SAD_W-1:0]  sad_t;
  typedef logic [DISP_W-1:0] disp_t;

endpackage
`default_nettype wire

// File: rtl/wta_min_update.sv
`default_nettype none
// ============================================================================
// Module      : wta_min_update
// Description : Combinational running-minimum update for one candidate cost.
//               Strict less-than, so ties keep the lower disparity.
//               Second-best tracking only with DISP_WTA_CONF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module wta_min_update #(
  parameter int SAD_W  = 12,
  parameter int DISP_W = 6
`ifdef DISP_WTA_CONF_EN
  , parameter int MAX_DISP = 64
`endif
) (
`ifdef DISP_WTA_CONF_EN
  input  logic [SAD_W-1:0]  second,
  output logic [SAD_W-1:0]  next_second,
`endif
  input  logic [SAD_W-1:0]  best,
  input  logic [DISP_W-1:0] disp,
  input  logic [SAD_W-1:0]  cost,
  input  logic [DISP_W-1:0] cnt,
  input  logic              first,
  output logic [SAD_W-1:0]  next_best,
  output logic [DISP_W-1:0] next_disp
);

  // Candidate 0 restarts the search; later candidates win only if strictly lower
  always_comb begin
    next_best = best;
    next_disp = disp;
`ifdef DISP_WTA_CONF_EN
    next_second = second;
`endif
    if (first) begin
      next_best = cost;
      next_disp = '0;
`ifdef DISP_WTA_CONF_EN
      // A lone candidate has no runner-up, so confidence saturates
      next_second = (MAX_DISP > 1) ? cost : '1;
`endif
    end else if (cost < best) begin
      next_best = cost;
      next_disp = cnt;
`ifdef DISP_WTA_CONF_EN
      next_second = best;
`endif
    end
`ifdef DISP_WTA_CONF_EN
    else if (cost < second) begin
      next_second = cost;
    end
`endif
  end

endmodule
`default_nettype wire

// File: rtl/disparity_wta.sv
`default_nettype none
// ============================================================================
// Module      : disparity_wta
// Description : Winner-take-all disparity selector. Consumes MAX_DISP SAD
//               costs per pixel and emits the winning disparity and its cost
//               through a valid/ready output register.
//               Optional macro DISP_WTA_CONF_EN adds conf_out (second - best).
// Revision    : 1.0 - initial release
// ============================================================================
module disparity_wta
  import stereo_pkg::disp_width;
#(
  parameter int SAD_W    = 12,
  parameter int MAX_DISP = 64
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            sad_valid,
  output logic                            sad_ready,
  input  logic [SAD_W-1:0]                sad_in,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [disp_width(MAX_DISP)-1:0] disp_out,
`ifdef DISP_WTA_CONF_EN
  output logic [SAD_W-1:0]                conf_out,
`endif
  output logic [SAD_W-1:0]                min_sad_out
);

  localparam int DISP_W = disp_width(MAX_DISP);
  localparam logic [DISP_W-1:0] LAST_CNT = DISP_W'(MAX_DISP - 1);

  logic [DISP_W-1:0] cnt;
  logic [SAD_W-1:0]  best_sad;
  logic [DISP_W-1:0] best_disp;
  logic [SAD_W-1:0]  next_best;
  logic [DISP_W-1:0] next_disp;
  logic              first;
  logic              last;
  logic              in_xfer;

  assign first   = (cnt == '0);
  assign last    = (cnt == LAST_CNT);
  // Only the final candidate needs room in the output register
  assign sad_ready = !last || !out_valid || out_ready;
  assign in_xfer   = sad_valid && sad_ready;

`ifdef DISP_WTA_CONF_EN
  logic [SAD_W-1:0] second_sad;
  logic [SAD_W-1:0] next_second;
`endif

  wta_min_update #(
    .SAD_W    (SAD_W),
    .DISP_W   (DISP_W)
`ifdef DISP_WTA_CONF_EN
    , .MAX_DISP (MAX_DISP)
`endif
  ) u_min_update (
`ifdef DISP_WTA_CONF_EN
    .second      (second_sad),
    .next_second (next_second),
`endif
    .best        (best_sad),
    .disp        (best_disp),
    .cost        (sad_in),
    .cnt         (cnt),
    .first       (first),
    .next_best   (next_best),
    .next_disp   (next_disp)
  );

  // Candidate counter, search state and output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      best_sad    <= '0;
      best_disp   <= '0;
      out_valid   <= 1'b0;
      disp_out    <= '0;
      min_sad_out <= '0;
`ifdef DISP_WTA_CONF_EN
      second_sad  <= '0;
      conf_out    <= '0;
`endif
    end else begin
      if (in_xfer) begin
        cnt       <= last ? '0 : cnt + 1'b1;
        best_sad  <= next_best;
        best_disp <= next_disp;
`ifdef DISP_WTA_CONF_EN
        second_sad <= next_second;
`endif
      end
      // A new result overrides a same-cycle drain so out_valid stays high
      if (in_xfer && last) begin
        out_valid   <= 1'b1;
        disp_out    <= next_disp;
        min_sad_out <= next_best;
`ifdef DISP_WTA_CONF_EN
        conf_out    <= next_second - next_best;
`endif
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_disparity_wta.sv
`default_nettype none
// ============================================================================
// Module      : tb_disparity_wta
// Description : Self-checking bench for disparity_wta, one instance with four
//               candidates and one with a single candidate, compared against
//               a per-pixel reference model. DISP_WTA_CONF_EN adds conf checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_disparity_wta;

  typedef struct {
    int d;
    int m;
    int cf;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        v4 = 1'b0, or4 = 1'b0;
  logic        r4, ov4;
  logic [11:0] sad4 = '0;
  logic [1:0]  d4;
  logic [11:0] m4;

  logic        v1 = 1'b0, or1 = 1'b0;
  logic        r1, ov1;
  logic [11:0] sad1 = '0;
  logic [0:0]  d1;
  logic [11:0] m1;

`ifdef DISP_WTA_CONF_EN
  logic [11:0] cf4, cf1;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  bit rand_rdy4 = 1'b0;
  bit rand_rdy1 = 1'b0;

  int   pix4[$];
  int   pix1[$];
  res_t exp4[$];
  res_t exp1[$];

  disparity_wta #(.SAD_W(12), .MAX_DISP(4)) dut4 (
    .clk         (clk),
    .rst_n       (rst_n),
    .sad_valid   (v4),
    .sad_ready   (r4),
    .sad_in      (sad4),
    .out_valid   (ov4),
    .out_ready   (or4),
    .disp_out    (d4),
`ifdef DISP_WTA_CONF_EN
    .conf_out    (cf4),
`endif
    .min_sad_out (m4)
  );

  disparity_wta #(.SAD_W(12), .MAX_DISP(1)) dut1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .sad_valid   (v1),
    .sad_ready   (r1),
    .sad_in      (sad1),
    .out_valid   (ov1),
    .out_ready   (or1),
    .disp_out    (d1),
`ifdef DISP_WTA_CONF_EN
    .conf_out    (cf1),
`endif
    .min_sad_out (m1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Winner = lowest cost, earliest index on ties. Runner-up = lowest cost
  // among the non-winners, except a winner at candidate 0 counts itself.
  function automatic res_t model(input int c[$], input int n);
    res_t r;
    int   sec;
    r.d = 0;
    r.m = c[0];
    for (int i = 1; i < n; i++)
      if (c[i] < r.m) begin
        r.m = c[i];
        r.d = i;
      end
    sec = (n > 1 && r.d == 0) ? c[0] : 4095;
    for (int i = 0; i < n; i++)
      if (i != r.d && c[i] < sec) sec = c[i];
    r.cf = sec - r.m;
    return r;
  endfunction

  // Monitor for the 4-candidate instance, sampled on the falling edge
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      check("rst4_valid", ov4, 0);
      check("rst4_ready", r4, 1);
      check("rst4_disp", d4, 0);
      check("rst4_min", m4, 0);
`ifdef DISP_WTA_CONF_EN
      check("rst4_conf", cf4, 0);
`endif
      pix4.delete();
      exp4.delete();
    end else begin
      check("valid4", ov4, (exp4.size() != 0) ? 1 : 0);
      check("ready4", r4, (pix4.size() != 3 || exp4.size() == 0 || or4) ? 1 : 0);
      if (exp4.size() != 0) begin
        check("disp4", d4, exp4[0].d);
        check("min4", m4, exp4[0].m);
`ifdef DISP_WTA_CONF_EN
        check("conf4", cf4, exp4[0].cf);
`endif
        if (or4) void'(exp4.pop_front());
      end
      if (v4 && r4) begin
        pix4.push_back(int'(sad4));
        if (pix4.size() == 4) begin
          exp4.push_back(model(pix4, 4));
          pix4.delete();
        end
      end
    end
  end

  // Monitor for the single-candidate instance
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      check("rst1_valid", ov1, 0);
      check("rst1_min", m1, 0);
      pix1.delete();
      exp1.delete();
    end else begin
      check("valid1", ov1, (exp1.size() != 0) ? 1 : 0);
      check("ready1", r1, (exp1.size() == 0 || or1) ? 1 : 0);
      if (exp1.size() != 0) begin
        check("disp1", d1, exp1[0].d);
        check("min1", m1, exp1[0].m);
`ifdef DISP_WTA_CONF_EN
        check("conf1", cf1, exp1[0].cf);
`endif
        if (or1) void'(exp1.pop_front());
      end
      if (v1 && r1) begin
        pix1.push_back(int'(sad1));
        exp1.push_back(model(pix1, 1));
        pix1.delete();
      end
    end
  end

  // Random downstream readiness when enabled
  initial forever begin
    @(posedge clk);
    #1;
    if (rand_rdy4) or4 = $urandom_range(0, 1);
    if (rand_rdy1) or1 = $urandom_range(0, 1);
  end

  task automatic drive4(input int c);
    int guard = 0;
    sad4 = c[11:0];
    v4   = 1'b1;
    @(negedge clk);
    while (!r4 && guard < 200) begin
      guard++;
      @(negedge clk);
    end
    if (guard >= 200) check("timeout4", 1, 0);
    @(posedge clk);
    #1;
    v4 = 1'b0;
  endtask

  task automatic drive1(input int c);
    int guard = 0;
    sad1 = c[11:0];
    v1   = 1'b1;
    @(negedge clk);
    while (!r1 && guard < 200) begin
      guard++;
      @(negedge clk);
    end
    if (guard >= 200) check("timeout1", 1, 0);
    @(posedge clk);
    #1;
    v1 = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int fixed4[] = '{40, 25, 30, 60, 10, 7, 7, 9};
  int bp4[]    = '{5, 6, 7, 8, 9, 3, 4, 1};
  int rst4[]   = '{50, 20, 20, 80};
  int fixed1[] = '{100, 0, 4095};

  initial begin
    idle(3);
    rst_n = 1'b1;
    or4   = 1'b1;
    or1   = 1'b1;
    idle(1);

    // Basic pixel and tie pixel with a ready sink
    foreach (fixed4[i]) drive4(fixed4[i]);
    idle(3);

    // Backpressure: pixel A then B while the sink stalls for 8 cycles
    or4 = 1'b0;
    fork
      foreach (bp4[i]) drive4(bp4[i]);
      begin
        idle(8);
        or4 = 1'b1;
      end
    join
    idle(4);

    // Continuous input with a ready sink: back-to-back results
    repeat (32) drive4($urandom_range(0, 4095));
    idle(3);

    // Reset in the middle of a pixel, then a fresh pixel
    drive4(111);
    drive4(222);
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(1);
    foreach (rst4[i]) drive4(rst4[i]);
    idle(3);

    // Random costs (narrow range to provoke ties), random sink and gaps
    rand_rdy4 = 1'b1;
    for (int i = 0; i < 400; i++) begin
      drive4(($urandom_range(0, 1) != 0) ? $urandom_range(0, 7) : $urandom_range(0, 4095));
      if ($urandom_range(0, 5) == 0) idle($urandom_range(1, 3));
    end
    rand_rdy4 = 1'b0;
    #1;
    or4 = 1'b1;
    idle(4);

    // Single-candidate instance: fixed costs then random traffic
    foreach (fixed1[i]) drive1(fixed1[i]);
    idle(2);
    rand_rdy1 = 1'b1;
    for (int i = 0; i < 100; i++) drive1($urandom_range(0, 4095));
    rand_rdy1 = 1'b0;
    #1;
    or1 = 1'b1;
    idle(4);

    check("drain4", exp4.size(), 0);
    check("drain1", exp1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
